// File: rtl/vend_ctrl_multi_pkg.sv
// Shared definitions for the multi-product vending controller: coin codes,
// FSM state encoding and the coin-code to unit-value mapping.
package vend_ctrl_multi_pkg;

  typedef enum logic [1:0] {
    COIN_5  = 2'd0,
    COIN_10 = 2'd1,
    COIN_25 = 2'd2,
    COIN_50 = 2'd3
  } coin_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_e;

  // Values are in 5-cent units.
  function automatic logic [3:0] coin_value(input logic [1:0] code);
    logic [3:0] val;
    case (code)
      COIN_5:  val = 4'd1;
      COIN_10: val = 4'd2;
      COIN_25: val = 4'd5;
      default: val = 4'd10;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vm_change_picker.sv
// Greedy change selector: offers the largest coin whose value does not
// exceed the remaining credit (order 10, 5, 2, 1 units).
module vm_change_picker
  import vend_ctrl_multi_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [1:0]          coin,
  output logic [3:0]          value
);

  always_comb begin
    if (credit >= CREDIT_W'(10))      coin = COIN_50;
    else if (credit >= CREDIT_W'(5))  coin = COIN_25;
    else if (credit >= CREDIT_W'(2))  coin = COIN_10;
    else                              coin = COIN_5;
    value = coin_value(coin);
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: credit accumulation, per-product pricing,
// cancel/refund and greedy change payout over a valid/ready hopper handshake.
module vend_ctrl_multi
  import vend_ctrl_multi_pkg::*;
#(
  parameter int                    NUM_PROD   = 4,
  parameter int                    CREDIT_W   = 8,
  parameter int                    MAX_CREDIT = 200,
  parameter logic [8*NUM_PROD-1:0] PRICES     = {8'd9, 8'd7, 8'd5, 8'd3},
  localparam int                   PID_W      = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_sel,
  input  logic                sel_valid,
  input  logic [PID_W-1:0]    sel_id,
  input  logic                cancel,
  output logic                vend,
  output logic [PID_W-1:0]    vend_id,
  output logic                coin_reject,
  output logic                sel_denied,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  input  logic                chg_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                vend_q, vend_d;
  logic [PID_W-1:0]    vend_id_q, vend_id_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_denied_q, sel_denied_d;
  logic                chg_valid_q, chg_valid_d;
  logic [1:0]          chg_coin_q, chg_coin_d;
  logic [3:0]          chg_val_q, chg_val_d;
  logic                busy_q, busy_d;

  logic [7:0]          sel_price;
  logic                id_ok;
  logic                sel_ok;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] pick_in;
  logic [1:0]          pick_coin;
  logic [3:0]          pick_val;

  always_comb begin
    sel_price = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (int'(sel_id) == i) sel_price = PRICES[8*i +: 8];
    end
  end

  assign id_ok    = (int'(sel_id) < NUM_PROD);
  assign sel_ok   = id_ok && ({1'b0, credit_q} >= (CREDIT_W+1)'(sel_price));
  // One extra bit so a coin that would overflow the register is still caught.
  assign coin_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_sel));

  // In CHANGE the picker looks at the credit left after the coin on offer,
  // so the next coin is ready the cycle after a handshake.
  assign pick_in = (state_q == ST_CHANGE) ? (credit_q - CREDIT_W'(chg_val_q)) : credit_q;

  vm_change_picker #(.CREDIT_W(CREDIT_W)) u_picker (
    .credit (pick_in),
    .coin   (pick_coin),
    .value  (pick_val)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_d        = 1'b0;
    vend_id_d     = vend_id_q;
    coin_reject_d = 1'b0;
    sel_denied_d  = 1'b0;
    chg_valid_d   = chg_valid_q;
    chg_coin_d    = chg_coin_q;
    chg_val_d     = chg_val_q;

    unique case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if ((state_q == ST_CREDIT) && cancel) begin
          state_d       = ST_CHANGE;
          chg_valid_d   = 1'b1;
          chg_coin_d    = pick_coin;
          chg_val_d     = pick_val;
          coin_reject_d = coin_valid;
        end else if ((state_q == ST_CREDIT) && sel_valid && sel_ok) begin
          state_d       = ST_VEND;
          credit_d      = credit_q - CREDIT_W'(sel_price);
          vend_d        = 1'b1;
          vend_id_d     = sel_id;
          coin_reject_d = coin_valid;
        end else begin
          // A refused selection does not block a coin arriving alongside it.
          sel_denied_d = sel_valid;
          if (coin_valid) begin
            if (coin_sum > MAX_C) begin
              coin_reject_d = 1'b1;
            end else begin
              credit_d = coin_sum[CREDIT_W-1:0];
              state_d  = ST_CREDIT;
            end
          end
        end
      end
      ST_VEND: begin
        coin_reject_d = coin_valid;
        if (credit_q != '0) begin
          state_d     = ST_CHANGE;
          chg_valid_d = 1'b1;
          chg_coin_d  = pick_coin;
          chg_val_d   = pick_val;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        coin_reject_d = coin_valid;
        if (chg_valid_q && chg_ready) begin
          credit_d = pick_in;
          if (pick_in == '0) begin
            state_d     = ST_IDLE;
            chg_valid_d = 1'b0;
            chg_coin_d  = COIN_5;
            chg_val_d   = '0;
          end else begin
            chg_coin_d = pick_coin;
            chg_val_d  = pick_val;
          end
        end
      end
    endcase

    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples its _d value from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      vend_q        <= 1'b0;
      vend_id_q     <= '0;
      coin_reject_q <= 1'b0;
      sel_denied_q  <= 1'b0;
      chg_valid_q   <= 1'b0;
      chg_coin_q    <= COIN_5;
      chg_val_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      vend_q        <= vend_d;
      vend_id_q     <= vend_id_d;
      coin_reject_q <= coin_reject_d;
      sel_denied_q  <= sel_denied_d;
      chg_valid_q   <= chg_valid_d;
      chg_coin_q    <= chg_coin_d;
      chg_val_q     <= chg_val_d;
      busy_q        <= busy_d;
    end
  end

  assign vend        = vend_q;
  assign vend_id     = vend_id_q;
  assign coin_reject = coin_reject_q;
  assign sel_denied  = sel_denied_q;
  assign chg_valid   = chg_valid_q;
  assign chg_coin    = chg_coin_q;
  assign credit      = credit_q;
  assign busy        = busy_q;

endmodule
